ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
REQ-002 SHALL have these pipeline control inputs:
- stall  in  1  hold contents
- flush  in  1  insert bubble
- ex_valid  in  1  EX holds a real instruction
REQ-003 SHALL have these EX data inputs:
- ALU_result  in  32
- Read_data2  in  32  store data
- PC_add_imm  in  32  branch target
- zero  in  1
- rd  in  5
REQ-004 SHALL have these EX control inputs, 1 bit each: RegWrite, MemRead, MemWrite, MemtoReg, Branch.
REQ-005 SHALL have these data outputs:
- mem_valid  out  1
- mem_ALU_result  out  32
- mem_Write_data  out  32
- mem_PC_add_imm  out  32
- mem_rd  out  5
REQ-006 SHALL have these control outputs, 1 bit each: mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg.
REQ-007 SHALL have these status outputs:
- PCSrc  out  1  taken branch in MEM
- branch_cnt  out  16  retired branches
- taken_cnt  out  16  retired taken branches
REQ-008 SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n); no other clock or reset.

Function
REQ-009 SHALL register all stage state on the rising clk edge, giving 1-cycle latency from EX inputs to mem_* outputs.
REQ-010 SHALL keep internal registers for Branch and zero, exposed only through PCSrc.
REQ-011 SHALL apply this per-edge priority: reset > flush > stall > load.
REQ-012 flush=1 SHALL load a bubble: valid=0, all control bits 0, data fields 0, rd 0.
REQ-013 stall=1 with flush=0 SHALL hold every register, counters included.
REQ-014 A load SHALL capture all inputs; valid=ex_valid; control bits are ANDed with ex_valid.
REQ-015 PCSrc SHALL be combinational: mem_valid & Branch_q & zero_q.
REQ-016 On a load edge where PCSrc=1, the stage SHALL load a bubble regardless of ex_valid, squashing the wrong-path instruction.
REQ-017 If PCSrc=1 and stall=1, PCSrc SHALL remain asserted until the stage advances.
REQ-018 mem_RegWrite, mem_MemRead, mem_MemWrite and mem_MemtoReg SHALL read 0 whenever mem_valid=0.
REQ-019 On each edge where the stage advances (stall=0) and the outgoing entry has mem_valid & Branch_q:
- branch_cnt SHALL increment by 1;
- taken_cnt SHALL also increment if zero_q=1.
REQ-020 Advancing under flush SHALL still retire the outgoing entry for counting.
REQ-021 Both counters SHALL saturate at 0xFFFF with no wrap.
REQ-022 Simultaneous flush=1 and stall=1: flush SHALL win.
REQ-023 Values SHALL pass through with no arithmetic or width change; mem_Write_data equals Read_data2.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, clear all outputs and registers to 0: mem_valid=0, PCSrc=0, counters=0.
REQ-025 Reset asserted mid-stall or mid-branch SHALL discard the held entry; the first edge after deassertion SHALL perform a normal load.

Verification
REQ-026 Load: ex_valid=1, ALU_result=0x00001234, Read_data2=0xDEADBEEF, rd=5, RegWrite=1, one edge -> mem_ALU_result=0x00001234, mem_Write_data=0xDEADBEEF, mem_rd=5, mem_RegWrite=1, mem_valid=1.
REQ-027 Taken branch: Branch=1, zero=1, PC_add_imm=0x00000040 loaded -> PCSrc=1, mem_PC_add_imm=0x40.
- Next edge with ex_valid=1, MemWrite=1 -> bubble loaded: mem_valid=0, mem_MemWrite=0.
- branch_cnt=1, taken_cnt=1.
REQ-028 Stall/flush: entry loaded, stall=1 for 3 cycles with new inputs -> outputs unchanged.
- flush=1 with stall=1 -> mem_valid=0, all control 0.
REQ-029 Counter saturation: counters preloaded to 0xFFFE, three not-taken branches retire -> branch_cnt=0xFFFF, taken_cnt unchanged.
REQ-030 Async reset: rst_n dropped between edges while PCSrc=1 -> PCSrc and mem_valid fall to 0 before the next edge; counters=0.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX -> MEM boundary bundle: pipeline control, EX-side payload and MEM-side results.
// The EX/hazard side drives through master; the pipeline register sits on slave.
interface ex_mem_if #(
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] Read_data2;
    logic [DATA_W-1:0] PC_add_imm;
    logic              zero;
    logic [4:0]        rd;
    logic              RegWrite;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              Branch;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_ALU_result;
    logic [DATA_W-1:0] mem_Write_data;
    logic [DATA_W-1:0] mem_PC_add_imm;
    logic [4:0]        mem_rd;
    logic              mem_RegWrite;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic              mem_MemtoReg;
    logic              PCSrc;
    logic [15:0]       branch_cnt;
    logic [15:0]       taken_cnt;

    modport master (
        output stall, flush, ex_valid, ALU_result, Read_data2, PC_add_imm, zero, rd,
               RegWrite, MemRead, MemWrite, MemtoReg, Branch,
        input  mem_valid, mem_ALU_result, mem_Write_data, mem_PC_add_imm, mem_rd,
               mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg,
               PCSrc, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, flush, ex_valid, ALU_result, Read_data2, PC_add_imm, zero, rd,
               RegWrite, MemRead, MemWrite, MemtoReg, Branch,
        output mem_valid, mem_ALU_result, mem_Write_data, mem_PC_add_imm, mem_rd,
               mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg,
               PCSrc, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush/stall, taken-branch squash and saturating
// retired-branch counters.
module ex_mem_reg #(
    parameter int DATA_W = 32
) (
    input logic   clk,
    input logic   rst_n,
    ex_mem_if.slave bus
);
    localparam int CNT_W = 16;

    logic              valid_p1;
    logic [DATA_W-1:0] alu_result_p1;
    logic [DATA_W-1:0] write_data_p1;
    logic [DATA_W-1:0] pc_add_imm_p1;
    logic [4:0]        rd_p1;
    logic              reg_write_p1;
    logic              mem_read_p1;
    logic              mem_write_p1;
    logic              memto_reg_p1;
    logic              branch_p1;
    logic              zero_p1;
    logic [CNT_W-1:0]  branch_cnt_p1;
    logic [CNT_W-1:0]  taken_cnt_p1;

    logic pcsrc;
    logic advance;
    logic bubble;
    logic retire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // A taken branch sitting in MEM squashes whatever EX offers on the next advance.
    assign pcsrc   = valid_p1 & branch_p1 & zero_p1;
    assign advance = bus.flush | ~bus.stall;
    assign bubble  = bus.flush | pcsrc;
    assign retire  = advance & valid_p1 & branch_p1;

    // EX -> MEM stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p1      <= 1'b0;
            alu_result_p1 <= '0;
            write_data_p1 <= '0;
            pc_add_imm_p1 <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            memto_reg_p1  <= 1'b0;
            branch_p1     <= 1'b0;
            zero_p1       <= 1'b0;
        end else if (advance) begin
            if (bubble) begin
                valid_p1      <= 1'b0;
                alu_result_p1 <= '0;
                write_data_p1 <= '0;
                pc_add_imm_p1 <= '0;
                rd_p1         <= '0;
                reg_write_p1  <= 1'b0;
                mem_read_p1   <= 1'b0;
                mem_write_p1  <= 1'b0;
                memto_reg_p1  <= 1'b0;
                branch_p1     <= 1'b0;
                zero_p1       <= 1'b0;
            end else begin
                valid_p1      <= bus.ex_valid;
                alu_result_p1 <= bus.ALU_result;
                write_data_p1 <= bus.Read_data2;
                pc_add_imm_p1 <= bus.PC_add_imm;
                rd_p1         <= bus.rd;
                reg_write_p1  <= bus.RegWrite & bus.ex_valid;
                mem_read_p1   <= bus.MemRead  & bus.ex_valid;
                mem_write_p1  <= bus.MemWrite & bus.ex_valid;
                memto_reg_p1  <= bus.MemtoReg & bus.ex_valid;
                branch_p1     <= bus.Branch   & bus.ex_valid;
                zero_p1       <= bus.zero;
            end
        end
    end

    // Retirement counters: count the entry leaving MEM, even when it leaves under flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_p1 <= '0;
            taken_cnt_p1  <= '0;
        end else if (retire) begin
            branch_cnt_p1 <= sat_inc(branch_cnt_p1);
            if (zero_p1) begin
                taken_cnt_p1 <= sat_inc(taken_cnt_p1);
            end
        end
    end

    assign bus.mem_valid      = valid_p1;
    assign bus.mem_ALU_result = alu_result_p1;
    assign bus.mem_Write_data = write_data_p1;
    assign bus.mem_PC_add_imm = pc_add_imm_p1;
    assign bus.mem_rd         = rd_p1;
    assign bus.mem_RegWrite   = valid_p1 & reg_write_p1;
    assign bus.mem_MemRead    = valid_p1 & mem_read_p1;
    assign bus.mem_MemWrite   = valid_p1 & mem_write_p1;
    assign bus.mem_MemtoReg   = valid_p1 & memto_reg_p1;
    assign bus.PCSrc          = pcsrc;
    assign bus.branch_cnt     = branch_cnt_p1;
    assign bus.taken_cnt      = taken_cnt_p1;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg: load, bubbles, stall/flush, branch squash,
// async reset and counter saturation.
module tb_ex_mem_reg;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ex_mem_if bus ();

    ex_mem_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [31:0] pc, input logic z, input logic [4:0] r,
                          input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic br);
        bus.ex_valid   = v;
        bus.ALU_result = alu;
        bus.Read_data2 = rd2;
        bus.PC_add_imm = pc;
        bus.zero       = z;
        bus.rd         = r;
        bus.RegWrite   = rw;
        bus.MemRead    = mr;
        bus.MemWrite   = mw;
        bus.MemtoReg   = m2r;
        bus.Branch     = br;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_ex(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd31,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %h want 0", bus.mem_valid); end
        n_cmp++; if (bus.PCSrc !== 1'b0) begin n_err++; $display("FAIL reset_pcsrc: got %h want 0", bus.PCSrc); end
        n_cmp++; if (bus.mem_ALU_result !== 32'h0) begin n_err++; $display("FAIL reset_alu: got %h want 0", bus.mem_ALU_result); end
        n_cmp++; if (bus.mem_RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %h want 0", bus.mem_RegWrite); end
        n_cmp++; if (bus.branch_cnt !== 16'h0 || bus.taken_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus.branch_cnt, bus.taken_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        set_ex(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd5,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.mem_ALU_result !== 32'h0000_1234) begin n_err++; $display("FAIL load_alu: got %h want 00001234", bus.mem_ALU_result); end
        n_cmp++; if (bus.mem_Write_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_wdata: got %h want deadbeef", bus.mem_Write_data); end
        n_cmp++; if (bus.mem_rd !== 5'd5) begin n_err++; $display("FAIL load_rd: got %0d want 5", bus.mem_rd); end
        n_cmp++; if (bus.mem_RegWrite !== 1'b1) begin n_err++; $display("FAIL load_regwrite: got %h want 1", bus.mem_RegWrite); end
        n_cmp++; if (bus.mem_valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %h want 1", bus.mem_valid); end
    endtask

    task automatic test_back_to_back();
        set_ex(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0100, 1'b0, 5'd31,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.mem_ALU_result !== 32'hA5A5_A5A5 || bus.mem_Write_data !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL b2b1_data: got %h/%h want a5a5a5a5/5a5a5a5a", bus.mem_ALU_result, bus.mem_Write_data); end
        n_cmp++; if (bus.mem_MemWrite !== 1'b1 || bus.mem_RegWrite !== 1'b0 || bus.mem_rd !== 5'd31) begin n_err++; $display("FAIL b2b1_ctl: got mw=%h rw=%h rd=%0d want 1 0 31", bus.mem_MemWrite, bus.mem_RegWrite, bus.mem_rd); end
        set_ex(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 5'd1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL b2b2_valid: got %h want 0", bus.mem_valid); end
        n_cmp++; if ({bus.mem_RegWrite, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_MemtoReg} !== 4'b0000) begin n_err++; $display("FAIL b2b2_ctl: got %b want 0000", {bus.mem_RegWrite, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_MemtoReg}); end
        n_cmp++; if (bus.PCSrc !== 1'b0) begin n_err++; $display("FAIL b2b2_pcsrc: got %h want 0", bus.PCSrc); end
        n_cmp++; if (bus.mem_ALU_result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b2_alu: got %h want ffffffff", bus.mem_ALU_result); end
        set_ex(1'b1, 32'h0000_FFFF, 32'h0, 32'h0, 1'b0, 5'd16,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_MemRead !== 1'b1 || bus.mem_MemtoReg !== 1'b1 || bus.mem_rd !== 5'd16) begin n_err++; $display("FAIL b2b3: got v=%h mr=%h m2r=%h rd=%0d want 1 1 1 16", bus.mem_valid, bus.mem_MemRead, bus.mem_MemtoReg, bus.mem_rd); end
        n_cmp++; if (bus.branch_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_cnt: got %0d want 0", bus.branch_cnt); end
    endtask

    task automatic test_taken_branch();
        set_ex(1'b1, 32'h0, 32'h0, 32'h0000_0040, 1'b1, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (bus.PCSrc !== 1'b1) begin n_err++; $display("FAIL br_pcsrc: got %h want 1", bus.PCSrc); end
        n_cmp++; if (bus.mem_PC_add_imm !== 32'h0000_0040) begin n_err++; $display("FAIL br_target: got %h want 00000040", bus.mem_PC_add_imm); end
        n_cmp++; if (bus.branch_cnt !== 16'd0) begin n_err++; $display("FAIL br_cnt_early: got %0d want 0", bus.branch_cnt); end
        set_ex(1'b1, 32'h1111_0000, 32'h0, 32'h0, 1'b0, 5'd3,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.mem_MemWrite !== 1'b0) begin n_err++; $display("FAIL br_squash: got v=%h mw=%h want 0 0", bus.mem_valid, bus.mem_MemWrite); end
        n_cmp++; if (bus.PCSrc !== 1'b0) begin n_err++; $display("FAIL br_pcsrc_clear: got %h want 0", bus.PCSrc); end
        n_cmp++; if (bus.branch_cnt !== 16'd1 || bus.taken_cnt !== 16'd1) begin n_err++; $display("FAIL br_cnt: got %0d/%0d want 1/1", bus.branch_cnt, bus.taken_cnt); end
    endtask

    task automatic test_stall_flush();
        set_ex(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 5'd7,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h9999_0000 + i, 32'h8888_8888, 32'h7777_7777, 1'b1, 5'd9,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
            n_cmp++; if (bus.mem_ALU_result !== 32'h1111_1111 || bus.mem_rd !== 5'd7 || bus.mem_Write_data !== 32'h2222_2222) begin n_err++; $display("FAIL stall_hold%0d: got %h rd=%0d wd=%h want 11111111 7 22222222", i, bus.mem_ALU_result, bus.mem_rd, bus.mem_Write_data); end
            n_cmp++; if (bus.branch_cnt !== 16'd1) begin n_err++; $display("FAIL stall_cnt%0d: got %0d want 1", i, bus.branch_cnt); end
        end
        n_cmp++; if (bus.mem_MemRead !== 1'b1 || bus.mem_MemWrite !== 1'b0 || bus.PCSrc !== 1'b0) begin n_err++; $display("FAIL stall_ctl: got mr=%h mw=%h pc=%h want 1 0 0", bus.mem_MemRead, bus.mem_MemWrite, bus.PCSrc); end
        bus.flush = 1'b1;
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %h want 0", bus.mem_valid); end
        n_cmp++; if ({bus.mem_RegWrite, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_MemtoReg} !== 4'b0000 || bus.mem_rd !== 5'd0 || bus.mem_ALU_result !== 32'h0) begin n_err++; $display("FAIL flush_clear: got ctl=%b rd=%0d alu=%h want 0000 0 0", {bus.mem_RegWrite, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_MemtoReg}, bus.mem_rd, bus.mem_ALU_result); end
        n_cmp++; if (bus.branch_cnt !== 16'd2 || bus.taken_cnt !== 16'd1) begin n_err++; $display("FAIL flush_retire: got %0d/%0d want 2/1", bus.branch_cnt, bus.taken_cnt); end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_stall_pcsrc();
        set_ex(1'b1, 32'h0, 32'h0, 32'h0000_0080, 1'b1, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bus.PCSrc !== 1'b1 || bus.mem_PC_add_imm !== 32'h0000_0080) begin n_err++; $display("FAIL stall_pcsrc%0d: got %h tgt=%h want 1 00000080", i, bus.PCSrc, bus.mem_PC_add_imm); end
        end
        n_cmp++; if (bus.branch_cnt !== 16'd2) begin n_err++; $display("FAIL stall_pcsrc_cnt: got %0d want 2", bus.branch_cnt); end
        bus.stall = 1'b0;
        set_ex(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd4,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.PCSrc !== 1'b0 || bus.mem_RegWrite !== 1'b0) begin n_err++; $display("FAIL pcsrc_release: got v=%h pc=%h rw=%h want 0 0 0", bus.mem_valid, bus.PCSrc, bus.mem_RegWrite); end
        n_cmp++; if (bus.branch_cnt !== 16'd3 || bus.taken_cnt !== 16'd2) begin n_err++; $display("FAIL pcsrc_cnt: got %0d/%0d want 3/2", bus.branch_cnt, bus.taken_cnt); end
    endtask

    task automatic test_async_reset();
        set_ex(1'b1, 32'h0, 32'h0, 32'h0000_0040, 1'b1, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (bus.PCSrc !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %h want 1", bus.PCSrc); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.PCSrc !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL arst_async: got pc=%h v=%h want 0 0", bus.PCSrc, bus.mem_valid); end
        n_cmp++; if (bus.branch_cnt !== 16'd0 || bus.taken_cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", bus.branch_cnt, bus.taken_cnt); end
        #2 rst_n = 1'b1;
        set_ex(1'b1, 32'hCAFE_F00D, 32'h0000_0001, 32'h0, 1'b0, 5'd12,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_ALU_result !== 32'hCAFE_F00D || bus.mem_rd !== 5'd12) begin n_err++; $display("FAIL arst_first_load: got v=%h alu=%h rd=%0d want 1 cafef00d 12", bus.mem_valid, bus.mem_ALU_result, bus.mem_rd); end
    endtask

    task automatic test_saturation();
        set_ex(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        n_cmp++; if (bus.branch_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload: got %h want fffe", bus.branch_cnt); end
        tick();
        tick();
        tick();
        n_cmp++; if (bus.branch_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_branch: got %h want ffff", bus.branch_cnt); end
        n_cmp++; if (bus.taken_cnt !== 16'h0000) begin n_err++; $display("FAIL sat_taken: got %h want 0000", bus.taken_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load();
        test_back_to_back();
        test_taken_branch();
        test_stall_flush();
        test_stall_pcsrc();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
